flt2int: RTL and testbench

Sequential half-precision-float to sign-magnitude-integer converter, the inverse of the int2flt path. It accepts one 16-bit float (1 sign, 5 exponent bits with bias 15, 10 mantissa bits) per start pulse. It produces a 16-bit integer: bit 15 is the sign, bits 14:0 are the magnitude, rounded to nearest-even. It sits beside the int2flt datapath, and its output is checked against the same memory-image format that int2flt consumes.

---
 rtl/flt2int.sv | 154 +++++++++++++++
 tb/tb_flt2int.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flt2int.sv
// Half-precision float to 16-bit sign-magnitude integer converter.
// Serial shifter: one bit of alignment per cycle, then round-to-nearest-even.
module flt2int (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] flt_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] int_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SHIFT,
        ST_ROUND
    } state_t;

    state_t      state_q, state_d;
    logic        s_q, s_d;
    logic [4:0]  e_q, e_d;
    logic [9:0]  m_q, m_d;
    logic [14:0] w_q, w_d;
    logic        g_q, g_d;
    logic        t_q, t_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] int_q, int_d;

    logic        round_up;
    logic [14:0] mag_sum;

    // Only right-shifted values ever round, and those stay far below 0x7FFF.
    assign round_up = g_q & (t_q | w_q[0]);
    assign mag_sum  = w_q + {14'd0, round_up};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        w_d     = w_q;
        g_d     = g_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        int_d   = int_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = flt_in[15];
                    e_d     = flt_in[14:10];
                    m_d     = flt_in[9:0];
                    busy_d  = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (e_q < 5'd14) begin
                    int_d   = {s_q, 15'd0};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (e_q >= 5'd30) begin
                    int_d   = {s_q, 15'h7FFF};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    w_d = {4'd0, 1'b1, m_q};
                    g_d = 1'b0;
                    t_d = 1'b0;
                    if (e_q >= 5'd25) begin
                        left_d = 1'b1;
                        cnt_d  = e_q - 5'd25;
                    end else begin
                        left_d = 1'b0;
                        cnt_d  = 5'd25 - e_q;
                    end
                    state_d = (cnt_d != 5'd0) ? ST_SHIFT : ST_ROUND;
                end
            end

            ST_SHIFT: begin
                if (left_q) begin
                    w_d = w_q << 1;
                end else begin
                    // Sticky collects every bit that falls past the guard position.
                    t_d = t_q | g_q;
                    g_d = w_q[0];
                    w_d = w_q >> 1;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                int_d   = {s_q, mag_sum};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_q     <= 1'b0;
            e_q     <= 5'd0;
            m_q     <= 10'd0;
            w_q     <= 15'd0;
            g_q     <= 1'b0;
            t_q     <= 1'b0;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            int_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            g_q     <= g_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            int_q   <= int_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign int_out = int_q;

endmodule

// File: tb/tb_flt2int.sv
// Self-checking bench for flt2int: directed cases plus a random sweep against
// a real-arithmetic reference (round half-even, saturate, sign pass-through).
module tb_flt2int;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] flt_in;
    logic        busy;
    logic        done;
    logic [15:0] int_out;

    flt2int dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flt_in  (flt_in),
        .busy    (busy),
        .done    (done),
        .int_out (int_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        pend[$];
    logic [15:0] last_res = 16'h0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact real value of the float, rounded half-even, saturated.
    function automatic logic [15:0] model(input logic [15:0] f);
        logic s;
        int   e;
        int   m;
        int   q;
        real  v;
        real  fr;
        s = f[15];
        e = int'(f[14:10]);
        m = int'(f[9:0]);
        if (e == 31) return {s, 15'h7FFF};
        if (e == 0) begin
            v = real'(m);
            for (int i = 0; i < 24; i++) v = v / 2.0;
        end else begin
            v = real'(1024 + m);
            if (e >= 25) for (int i = 0; i < e - 25; i++) v = v * 2.0;
            else         for (int i = 0; i < 25 - e; i++) v = v / 2.0;
        end
        q  = $rtoi(v);
        fr = v - real'(q);
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q = q + 1;
        if (q > 32767) q = 32767;
        return {s, q[14:0]};
    endfunction

    function automatic int model_lat(input logic [15:0] f);
        int e;
        e = int'(f[14:10]);
        if (e < 14 || e >= 30) return 1;
        if (e >= 25) return 2 + (e - 25);
        return 2 + (25 - e);
    endfunction

    // Compare process: every cycle out of reset, done must match a pending
    // conversion (value and latency); when idle, int_out must hold.
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            if (done) begin
                if (pend.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 int_out=%h expected no done (cycle %0d)", int_out, cyc);
                end else begin
                    x = pend.pop_front();
                    check("int_out", {16'd0, int_out}, {16'd0, x.val});
                    check("latency", cyc, x.due);
                    last_res = x.val;
                end
            end else if (pend.size() == 0) begin
                check("hold", {16'd0, int_out}, {16'd0, last_res});
            end
        end
    end

    task automatic launch(input logic [15:0] f, input logic [15:0] xv);
        exp_t x;
        start  = 1'b1;
        flt_in = f;
        x.val  = xv;
        x.due  = cyc + 1 + model_lat(f);
        pend.push_back(x);
    endtask

    task automatic wait_done(input bit junk);
        for (int n = 0; n < 20 && !done; n++) begin
            start  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            flt_in = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done expected done within 20 cycles (cycle %0d)", cyc);
            pend.delete();
        end else begin
            check("busy_at_done", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic run(input logic [15:0] f, input logic [15:0] xv, input bit junk);
        launch(f, xv);
        @(negedge clk);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(junk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f;
        reset  = 1'b0;
        start  = 1'b0;
        flt_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_int",  {16'd0, int_out}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Pin the reference model with hand-computed values.
        check("model_3C00", {16'd0, model(16'h3C00)}, 32'h0001);
        check("model_C500", {16'd0, model(16'hC500)}, 32'h8005);
        check("model_3800", {16'd0, model(16'h3800)}, 32'h0000);
        check("model_3A00", {16'd0, model(16'h3A00)}, 32'h0001);
        check("model_3E00", {16'd0, model(16'h3E00)}, 32'h0002);
        check("model_4100", {16'd0, model(16'h4100)}, 32'h0002);
        check("model_77FF", {16'd0, model(16'h77FF)}, 32'h7FF0);
        check("model_7800", {16'd0, model(16'h7800)}, 32'h7FFF);
        check("model_FC00", {16'd0, model(16'hFC00)}, 32'hFFFF);
        check("lat_3C00", model_lat(16'h3C00), 12);
        check("lat_C500", model_lat(16'hC500), 10);
        check("lat_77FF", model_lat(16'h77FF), 6);
        check("lat_7800", model_lat(16'h7800), 1);

        // Directed values with literal expectations.
        run(16'h3C00, 16'h0001, 1'b0);
        run(16'hC500, 16'h8005, 1'b0);
        run(16'h3800, 16'h0000, 1'b0);
        run(16'h3A00, 16'h0001, 1'b0);
        run(16'h3E00, 16'h0002, 1'b0);
        run(16'h4100, 16'h0002, 1'b0);
        run(16'h77FF, 16'h7FF0, 1'b0);
        run(16'h7800, 16'h7FFF, 1'b0);
        run(16'hFC00, 16'hFFFF, 1'b0);
        run(16'h0001, 16'h0000, 1'b0);
        run(16'h8000, 16'h8000, 1'b0);
        repeat (2) @(negedge clk);

        // start while busy is ignored; start right after done is accepted.
        launch(16'h3C00, 16'h0001);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        flt_in = 16'h4100;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
        run(16'h4100, 16'h0002, 1'b0);
        repeat (2) @(negedge clk);

        // Reset mid-operation aborts with no done.
        launch(16'h3C00, 16'h0001);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        pend.delete();
        last_res = 16'h0000;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_int",  {16'd0, int_out}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_int_hold", {16'd0, int_out}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run(16'h3E00, 16'h0002, 1'b0);

        // Random sweep, biased toward the shifting exponent range.
        for (int k = 0; k < 300; k++) begin
            f = 16'($urandom);
            if ($urandom_range(0, 1) == 1) f[14:10] = 5'($urandom_range(12, 31));
            run(f, model(f), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_empty", pend.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
